i2s_rx_channel: RTL and testbench

I2S_RX_CHANNEL -- requirements
Module: i2s_rx_channel

---
 rtl/i2s_pkg.sv | 18 +
 rtl/i2s_rx_fifo.sv | 84 ++++++++
 rtl/i2s_rx_channel.sv | 175 +++++++++++++++++
 tb/tb_i2s_rx_channel.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/i2s_pkg.sv
// Shared definitions for the I2S receive channel.
//   - rx_state_e  : receive FSM state encoding
//   - MAX_WORD_W  : widest supported word (bits)
//   - BITCNT_W    : width of the in-word bit counter
//   - WORDCNT_W   : width of the in-frame word (slot) counter
package i2s_pkg;

  localparam int MAX_WORD_W = 32;
  localparam int BITCNT_W   = 5;
  localparam int WORDCNT_W  = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SYNC = 2'd1,
    ST_RUN  = 2'd2
  } rx_state_e;

endpackage

// File: rtl/i2s_rx_fifo.sv
// Output word buffer for the I2S receive channel.
// Ports:
//   clk_i, rst_i     : clock, asynchronous active-high reset
//   flush_i          : synchronous empty (takes priority over push/pop)
//   push_i/push_data : write request; dropped when full unless a pop
//                      happens in the same cycle
//   pop_i            : read request (ignored while empty)
//   pop_data_o       : head entry, reads 0 while empty
//   full_o, empty_o  : occupancy flags
//   drop_o           : a push was refused this cycle
module i2s_rx_fifo #(
  parameter int FIFO_DEPTH = 2,
  parameter int DATA_W     = 35
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              push_i,
  input  logic [DATA_W-1:0] push_data_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] pop_data_o,
  output logic              full_o,
  output logic              empty_o,
  output logic              drop_o
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [DATA_W-1:0] mem_d [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       count_q, count_d;
  logic              do_push, do_pop;

  assign full_o     = (count_q == DEPTH_C);
  assign empty_o    = (count_q == '0);
  assign pop_data_o = empty_o ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    do_pop   = pop_i & ~empty_o;
    // A full buffer still accepts a push when the head leaves this cycle.
    do_push  = push_i & (~full_o | do_pop);
    drop_o   = push_i & full_o & ~do_pop;

    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      drop_o   = 1'b0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data_i;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (do_pop) rd_ptr_d = rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + (AW+1)'(1);
        2'b01:   count_d = count_q - (AW+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/i2s_rx_channel.sv
// I2S receive channel: deserialises sd_i into words framed by ws_i rising
// edges (one-bit I2S delay), buffers completed words with their slot index.
// Ports:
//   clk_i, rst_i        : bit clock, asynchronous active-high reset
//   cfg_en_i            : enable; low flushes the buffer and idles the FSM
//   cfg_word_size_i     : bits per word minus 1
//   cfg_word_num_i      : words per frame minus 1
//   cfg_lsb_first_i     : first received bit is the LSB
//   ws_i, sd_i          : word select, serial data
//   data_o/word_idx_o   : head word (right-justified) and its slot index
//   data_valid_o        : head is valid; popped with data_ready_i
//   overflow_o          : sticky, word dropped on full buffer
//   frame_err_o         : sticky, ws edge early or missing
//   status_clr_i        : clears both sticky flags (a same-cycle set wins)
module i2s_rx_channel
  import i2s_pkg::*;
#(
  parameter int FIFO_DEPTH = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cfg_en_i,
  input  logic [BITCNT_W-1:0]   cfg_word_size_i,
  input  logic [WORDCNT_W-1:0]  cfg_word_num_i,
  input  logic                  cfg_lsb_first_i,
  input  logic                  ws_i,
  input  logic                  sd_i,
  output logic [MAX_WORD_W-1:0] data_o,
  output logic                  data_valid_o,
  input  logic                  data_ready_i,
  output logic [WORDCNT_W-1:0]  word_idx_o,
  output logic                  overflow_o,
  output logic                  frame_err_o,
  input  logic                  status_clr_i
);

  localparam int ENTRY_W = WORDCNT_W + MAX_WORD_W;

  rx_state_e              state_q, state_d;
  logic                   ws_q, ws_d;
  logic [BITCNT_W-1:0]    bitcnt_q, bitcnt_d;
  logic [WORDCNT_W-1:0]   wordcnt_q, wordcnt_d;
  logic [MAX_WORD_W-1:0]  shreg_q, shreg_d;
  logic                   overflow_q, overflow_d;
  logic                   frame_err_q, frame_err_d;

  logic                   ws_edge;
  logic                   final_bit, last_word;
  logic [MAX_WORD_W-1:0]  base, sampled;
  logic                   push, flush, fe_set;
  logic [ENTRY_W-1:0]     push_data, head;
  logic                   fifo_full, fifo_empty, fifo_drop, pop;

  assign ws_edge   = ws_i & ~ws_q;
  assign final_bit = (bitcnt_q == cfg_word_size_i);
  assign last_word = (wordcnt_q == cfg_word_num_i);

  // Bit 0 of a word starts from an empty register so short words read
  // zero above their width.
  assign base    = (bitcnt_q == '0) ? '0 : shreg_q;
  assign sampled = cfg_lsb_first_i
                 ? (base | ({{(MAX_WORD_W-1){1'b0}}, sd_i} << bitcnt_q))
                 : {base[MAX_WORD_W-2:0], sd_i};

  // The word is written into the buffer on the same edge that samples its
  // final bit, so it is visible on data_o in the following cycle.
  assign push_data = {wordcnt_q, sampled};

  always_comb begin
    state_d   = state_q;
    ws_d      = ws_i;
    bitcnt_d  = bitcnt_q;
    wordcnt_d = wordcnt_q;
    shreg_d   = shreg_q;
    push      = 1'b0;
    flush     = 1'b0;
    fe_set    = 1'b0;

    if (!cfg_en_i) begin
      state_d   = ST_IDLE;
      bitcnt_d  = '0;
      wordcnt_d = '0;
      shreg_d   = '0;
      flush     = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_SYNC;
        ST_SYNC: begin
          if (ws_edge) begin
            state_d   = ST_RUN;
            bitcnt_d  = '0;
            wordcnt_d = '0;
            shreg_d   = '0;
          end
        end
        ST_RUN: begin
          if (final_bit && last_word) begin
            // End of frame: the next frame's ws edge must land here.
            push      = 1'b1;
            bitcnt_d  = '0;
            wordcnt_d = '0;
            shreg_d   = '0;
            if (!ws_edge) begin
              fe_set  = 1'b1;
              state_d = ST_SYNC;
            end
          end else if (ws_edge) begin
            // Early edge: drop the partial word, resync to slot 0.
            fe_set    = 1'b1;
            bitcnt_d  = '0;
            wordcnt_d = '0;
            shreg_d   = '0;
          end else if (final_bit) begin
            push      = 1'b1;
            bitcnt_d  = '0;
            wordcnt_d = wordcnt_q + WORDCNT_W'(1);
            shreg_d   = '0;
          end else begin
            bitcnt_d  = bitcnt_q + BITCNT_W'(1);
            shreg_d   = sampled;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    overflow_d  = fifo_drop ? 1'b1 : (status_clr_i ? 1'b0 : overflow_q);
    frame_err_d = fe_set    ? 1'b1 : (status_clr_i ? 1'b0 : frame_err_q);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      ws_q        <= 1'b0;
      bitcnt_q    <= '0;
      wordcnt_q   <= '0;
      shreg_q     <= '0;
      overflow_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ws_q        <= ws_d;
      bitcnt_q    <= bitcnt_d;
      wordcnt_q   <= wordcnt_d;
      shreg_q     <= shreg_d;
      overflow_q  <= overflow_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign pop = ~fifo_empty & data_ready_i;

  i2s_rx_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .DATA_W     (ENTRY_W)
  ) u_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .flush_i     (flush),
    .push_i      (push),
    .push_data_i (push_data),
    .pop_i       (pop),
    .pop_data_o  (head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .drop_o      (fifo_drop)
  );

  assign data_o       = head[MAX_WORD_W-1:0];
  assign word_idx_o   = head[ENTRY_W-1:MAX_WORD_W];
  assign data_valid_o = ~fifo_empty;
  assign overflow_o   = overflow_q;
  assign frame_err_o  = frame_err_q;

endmodule

// File: tb/tb_i2s_rx_channel.sv
// Scoreboard bench for i2s_rx_channel: stimulus pushes expected words,
// a negedge monitor pops and compares whenever a word is handed over.
module tb_i2s_rx_channel;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        cfg_en_i;
  logic [4:0]  cfg_word_size_i;
  logic [2:0]  cfg_word_num_i;
  logic        cfg_lsb_first_i;
  logic        ws_i, sd_i;
  logic [31:0] data_o;
  logic        data_valid_o;
  logic        data_ready_i;
  logic [2:0]  word_idx_o;
  logic        overflow_o, frame_err_o;
  logic        status_clr_i;

  always #5 clk_i = ~clk_i;

  i2s_rx_channel #(.FIFO_DEPTH(2)) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .cfg_en_i        (cfg_en_i),
    .cfg_word_size_i (cfg_word_size_i),
    .cfg_word_num_i  (cfg_word_num_i),
    .cfg_lsb_first_i (cfg_lsb_first_i),
    .ws_i            (ws_i),
    .sd_i            (sd_i),
    .data_o          (data_o),
    .data_valid_o    (data_valid_o),
    .data_ready_i    (data_ready_i),
    .word_idx_o      (word_idx_o),
    .overflow_o      (overflow_o),
    .frame_err_o     (frame_err_o),
    .status_clr_i    (status_clr_i)
  );

  typedef struct packed { logic [31:0] d; logic [2:0] idx; } exp_t;
  exp_t sbq[$];
  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  function automatic logic [31:0] mask_n(input int n);
    mask_n = (n >= 32) ? 32'hFFFF_FFFF : ((32'h1 << n) - 32'h1);
  endfunction

  // Monitor: every handshake consumes the oldest expected word.
  always @(negedge clk_i) begin
    exp_t e;
    if (!rst_i && data_valid_o && data_ready_i) begin
      if (sbq.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_word: got data %h idx %0d, expected no word", data_o, word_idx_o);
      end else begin
        e = sbq.pop_front();
        check("word_data", data_o, e.d);
        check("word_idx", {29'b0, word_idx_o}, {29'b0, e.idx});
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic cyc(input logic ws, input logic sd);
    ws_i = ws;
    sd_i = sd;
    @(posedge clk_i);
    #1;
  endtask

  // Disable (flushes and clears flags), load config, re-enable into SYNC.
  task automatic setup(input int n, input int w, input bit lsb);
    cfg_en_i = 1'b0;
    cyc(0, 0);
    status_clr_i = 1'b1;
    cyc(0, 0);
    status_clr_i = 1'b0;
    cfg_word_size_i = 5'(n - 1);
    cfg_word_num_i  = 3'(w - 1);
    cfg_lsb_first_i = lsb;
    cfg_en_i = 1'b1;
    cyc(0, 0);
    cyc(0, 0);
  endtask

  // Serialise one word; optionally raise ws on its last bit (next frame start).
  task automatic send_word(input logic [31:0] w, input int n, input bit lsb,
                           input bit ws_last, input bit expect_it, input int idx);
    exp_t e;
    if (expect_it) begin
      e.d   = w & mask_n(n);
      e.idx = idx[2:0];
      sbq.push_back(e);
    end
    for (int i = 0; i < n; i++)
      cyc(ws_last && (i == n - 1), lsb ? w[i] : w[n - 1 - i]);
  endtask

  initial begin
    logic [31:0] w0, w1, w2, held;
    int n, w, k;
    bit lsb;

    rst_i = 1'b1; cfg_en_i = 1'b0; cfg_word_size_i = '0; cfg_word_num_i = '0;
    cfg_lsb_first_i = 1'b0; ws_i = 1'b0; sd_i = 1'b0; data_ready_i = 1'b1;
    status_clr_i = 1'b0;
    #2;
    check("rst_data", data_o, 0);
    check("rst_valid", {31'b0, data_valid_o}, 0);
    check("rst_idx", {29'b0, word_idx_o}, 0);
    check("rst_overflow", {31'b0, overflow_o}, 0);
    check("rst_frame_err", {31'b0, frame_err_o}, 0);
    @(posedge clk_i); #1;
    rst_i = 1'b0;

    // Normal frame, MSB-first, valid one cycle after each last bit.
    setup(16, 2, 0);
    cyc(1, 0);
    check("nf_valid_before", {31'b0, data_valid_o}, 0);
    send_word(32'hA5C3, 16, 0, 0, 1, 0);
    check("nf_valid_w0", {31'b0, data_valid_o}, 1);
    send_word(32'h1234, 16, 0, 1, 1, 1);
    check("nf_valid_w1", {31'b0, data_valid_o}, 1);
    check("nf_frame_err", {31'b0, frame_err_o}, 0);

    // LSB-first single-slot word.
    setup(8, 1, 1);
    cyc(1, 0);
    send_word(32'h1, 8, 1, 1, 1, 0);
    check("lsb_data", data_o, 32'h1);

    // Back-pressure: two held, third dropped.
    setup(16, 1, 0);
    data_ready_i = 1'b0;
    w0 = $urandom; w1 = $urandom; w2 = $urandom;
    cyc(1, 0);
    send_word(w0, 16, 0, 1, 1, 0);
    send_word(w1, 16, 0, 1, 1, 0);
    send_word(w2, 16, 0, 1, 0, 0);
    held = w0 & 32'hFFFF;
    check("bp_overflow", {31'b0, overflow_o}, 1);
    check("bp_valid", {31'b0, data_valid_o}, 1);
    check("bp_head", data_o, held);
    cyc(0, 1);
    check("bp_hold1", data_o, held);
    cyc(0, 0);
    check("bp_hold2", data_o, held);
    status_clr_i = 1'b1;
    cyc(0, 0);
    status_clr_i = 1'b0;
    check("bp_clr", {31'b0, overflow_o}, 0);
    data_ready_i = 1'b1;
    cyc(0, 0); cyc(0, 0); cyc(0, 0);
    check("bp_drained", {31'b0, data_valid_o}, 0);

    // Early ws at bit 5 of word 1.
    setup(16, 2, 0);
    w1 = $urandom;
    cyc(1, 0);
    send_word($urandom, 16, 0, 0, 1, 0);
    for (int i = 0; i < 5; i++) cyc(0, w1[15 - i]);
    cyc(1, w1[10]);
    check("early_frame_err", {31'b0, frame_err_o}, 1);
    send_word($urandom, 16, 0, 0, 1, 0);
    send_word($urandom, 16, 0, 1, 1, 1);

    // Missing ws at frame end.
    setup(8, 1, 0);
    cyc(1, 0);
    check("miss_err_before", {31'b0, frame_err_o}, 0);
    send_word($urandom, 8, 0, 0, 1, 0);
    check("miss_frame_err", {31'b0, frame_err_o}, 1);
    for (int i = 0; i < 24; i++) cyc(0, 1'($urandom));
    check("miss_no_word", {31'b0, data_valid_o}, 0);
    cyc(1, 0);
    send_word($urandom, 8, 0, 1, 1, 0);

    // Reset mid-word with one word buffered.
    setup(8, 1, 0);
    data_ready_i = 1'b0;
    cyc(1, 0);
    send_word($urandom | 32'h80, 8, 0, 1, 1, 0);
    check("rm_valid", {31'b0, data_valid_o}, 1);
    cyc(0, 1); cyc(0, 1); cyc(0, 1);
    #2 rst_i = 1'b1;
    #1;
    check("rm_data", data_o, 0);
    check("rm_valid0", {31'b0, data_valid_o}, 0);
    check("rm_idx", {29'b0, word_idx_o}, 0);
    check("rm_overflow", {31'b0, overflow_o}, 0);
    check("rm_frame_err", {31'b0, frame_err_o}, 0);
    sbq.delete();
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    data_ready_i = 1'b1;
    for (int i = 0; i < 20; i++) cyc(0, 1'($urandom));
    check("rm_no_word", {31'b0, data_valid_o}, 0);
    cyc(1, 0);
    send_word($urandom, 8, 0, 1, 1, 0);

    // Randomised frames.
    for (int r = 0; r < 8; r++) begin
      n = $urandom_range(1, 32);
      w = $urandom_range(1, 8);
      if (n * w < 2) n = 2;
      lsb = 1'($urandom);
      k = $urandom_range(1, 3);
      setup(n, w, lsb);
      data_ready_i = 1'b1;
      cyc(1, 1'($urandom));
      for (int f = 0; f < k; f++)
        for (int j = 0; j < w; j++)
          send_word($urandom, n, lsb, j == w - 1, 1, j);
      check("rnd_frame_err", {31'b0, frame_err_o}, 0);
      check("rnd_overflow", {31'b0, overflow_o}, 0);
    end

    cfg_en_i = 1'b0;
    for (int i = 0; i < 4; i++) cyc(0, 0);
    check("sb_drained", sbq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
